// File: rtl/character_motion.sv
// Frame-stepped jump/gravity controller for a sprite's vertical position.
// Optional feature macro: CHARACTER_DOUBLE_JUMP_EN (one mid-air re-jump per flight).
module character_motion #(
  parameter int GROUND_Y = 400,
  parameter int CEIL_Y   = 20,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_jump,
  output logic [8:0] o_ypos,
  output logic       o_airborne,
  output logic       o_land
);

  typedef enum logic [1:0] {GROUND, RISING, FALLING} state_t;

  localparam logic [9:0]        GROUND_Y10 = 10'(GROUND_Y);
  localparam logic [8:0]        GROUND_Y9  = 9'(GROUND_Y);
  localparam logic [8:0]        CEIL_Y9    = 9'(CEIL_Y);
  localparam logic signed [10:0] CEIL_S    = 11'(CEIL_Y);
  localparam logic [4:0]        JUMP_V5    = 5'(JUMP_V0);
  localparam logic [4:0]        GRAV5      = 5'(GRAVITY);
  localparam logic [4:0]        VMAX5      = 5'(VMAX);

  state_t r_state, w_state_nxt;
  logic [8:0] r_y, w_y_nxt;
  logic [4:0] r_v, w_v_nxt;
  logic r_jump_s1, r_jump_s2, r_jump_s3;
  logic r_pending, r_land, w_land_nxt;
  logic w_jump_edge, w_jump_req, w_ceil_hit, w_land_hit;
  logic signed [10:0] w_rise_y;
  logic [5:0] w_fall_v;
  logic [9:0] w_fall_y;
`ifdef CHARACTER_DOUBLE_JUMP_EN
  logic r_dj_used, w_dj_used_nxt;
`endif

  // Falling speed after one gravity step, saturated at terminal velocity.
  function automatic logic [5:0] fall_speed(input logic [4:0] v);
    logic [5:0] sum;
    sum = {1'b0, v} + {1'b0, GRAV5};
    if (sum > {1'b0, VMAX5}) sum = {1'b0, VMAX5};
    return sum;
  endfunction

  assign w_jump_edge = r_jump_s2 & ~r_jump_s3;
  assign w_jump_req  = r_pending | w_jump_edge;
  assign w_rise_y    = $signed({2'b00, r_y}) - $signed({6'd0, r_v});
  assign w_ceil_hit  = (w_rise_y < CEIL_S);
  assign w_fall_v    = fall_speed(r_v);
  assign w_fall_y    = {1'b0, r_y} + {4'd0, w_fall_v};
  assign w_land_hit  = (w_fall_y >= GROUND_Y10);

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_v_nxt     = r_v;
    w_land_nxt  = 1'b0;
`ifdef CHARACTER_DOUBLE_JUMP_EN
    w_dj_used_nxt = r_dj_used;
`endif
    if (i_frame_tick) begin
      case (r_state)
        GROUND: begin
          if (w_jump_req) begin
            w_state_nxt = RISING;
            w_v_nxt     = JUMP_V5;
          end else begin
            w_y_nxt = GROUND_Y9;
            w_v_nxt = 5'd0;
          end
        end
        RISING: begin
          w_y_nxt = w_ceil_hit ? CEIL_Y9 : w_rise_y[8:0];
          if (r_v <= GRAV5 || w_ceil_hit) begin
            w_state_nxt = FALLING;
            w_v_nxt     = 5'd0;
          end else begin
            w_v_nxt = r_v - GRAV5;
          end
        end
        FALLING: begin
          if (w_land_hit) begin
            w_state_nxt = GROUND;
            w_y_nxt     = GROUND_Y9;
            w_v_nxt     = 5'd0;
            w_land_nxt  = 1'b1;
`ifdef CHARACTER_DOUBLE_JUMP_EN
            w_dj_used_nxt = 1'b0;
`endif
          end else begin
            w_y_nxt = w_fall_y[8:0];
            w_v_nxt = w_fall_v[4:0];
          end
        end
        default: w_state_nxt = GROUND;
      endcase
`ifdef CHARACTER_DOUBLE_JUMP_EN
      // Re-jump overrides whatever the airborne step computed, landing included.
      if (r_state != GROUND && w_jump_req && !r_dj_used) begin
        w_state_nxt   = RISING;
        w_y_nxt       = r_y;
        w_v_nxt       = JUMP_V5;
        w_land_nxt    = 1'b0;
        w_dj_used_nxt = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_jump_s1 <= 1'b0;
      r_jump_s2 <= 1'b0;
      r_jump_s3 <= 1'b0;
      r_pending <= 1'b0;
      r_state   <= GROUND;
      r_y       <= GROUND_Y9;
      r_v       <= 5'd0;
      r_land    <= 1'b0;
`ifdef CHARACTER_DOUBLE_JUMP_EN
      r_dj_used <= 1'b0;
`endif
    end else begin
      r_jump_s1 <= i_jump;
      r_jump_s2 <= r_jump_s1;
      r_jump_s3 <= r_jump_s2;
      // Every tick consumes the request, even when the state ignores it.
      if (i_frame_tick)     r_pending <= 1'b0;
      else if (w_jump_edge) r_pending <= 1'b1;
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_v     <= w_v_nxt;
      r_land  <= w_land_nxt;
`ifdef CHARACTER_DOUBLE_JUMP_EN
      r_dj_used <= w_dj_used_nxt;
`endif
    end
  end

  assign o_ypos     = r_y;
  assign o_airborne = (r_state != GROUND);
  assign o_land     = r_land;

endmodule

// File: tb/tb_character_motion.sv
// Directed bench for character_motion: default instance plus a JUMP_V0=31 instance.
module tb_character_motion;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic jump = 1'b0;
  logic [8:0] ypos, ypos_hi;
  logic air, air_hi, land, land_hi;
  int n_checks = 0;
  int n_fail = 0;
  int land_cnt = 0;
  int land_cnt_hi = 0;

  character_motion u_dut (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_jump(jump),
    .o_ypos(ypos), .o_airborne(air), .o_land(land)
  );

  character_motion #(.JUMP_V0(31)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_jump(jump),
    .o_ypos(ypos_hi), .o_airborne(air_hi), .o_land(land_hi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (land)    land_cnt++;
    if (land_hi) land_cnt_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; jump = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic pulse_jump();
    @(negedge clk) jump = 1'b1;
    repeat (4) @(negedge clk);
    jump = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Default-parameter trajectory after the entry tick, hand-computed.
  task automatic run_traj(input string tag, input int inject_at);
    int exp_y [2:25];
    int base;
    exp_y = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
              323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};
    base = land_cnt;
    for (int k = 2; k <= 25; k++) begin
      if (k == inject_at) pulse_jump();
      do_tick();
      check($sformatf("%s_y_t%0d", tag, k), ypos, exp_y[k]);
      if (k == 13 || k == 24 || k == 25)
        check($sformatf("%s_air_t%0d", tag, k), air, (k == 25) ? 0 : 1);
    end
    repeat (2) @(negedge clk);
    check({tag, "_land_once"}, land_cnt - base, 1);
    do_tick();
    do_tick();
    check({tag, "_no_extra_land"}, land_cnt - base, 1);
  endtask

  initial begin
    int base;
    int miny;

    // Reset state and idle ticks
    do_reset();
    check("rst_y", ypos, 400);
    check("rst_air", air, 0);
    check("rst_land", land, 0);
    base = land_cnt;
    repeat (5) do_tick();
    check("idle_y", ypos, 400);
    check("idle_air", air, 0);
    check("idle_land", land_cnt - base, 0);

    // Basic jump
    do_reset();
    pulse_jump();
    do_tick();
    check("j_t1_y", ypos, 400);
    check("j_t1_air", air, 1);
    run_traj("j", 0);

    // Jump edge coincident with a tick
    do_reset();
    @(negedge clk) jump = 1'b1;
    @(negedge clk);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    check("co_air", air, 1);
    check("co_y", ypos, 400);
    repeat (3) @(negedge clk);
    jump = 1'b0;
    repeat (3) @(negedge clk);
`ifndef CHARACTER_DOUBLE_JUMP_EN
    run_traj("co2", 5);
`else
    run_traj("co", 0);
`endif

    // Ceiling clamp and terminal velocity with JUMP_V0=31
    do_reset();
    pulse_jump();
    miny = 511;
    for (int k = 1; k <= 35; k++) begin
      do_tick();
      if (ypos_hi < miny) miny = ypos_hi;
      case (k)
        17: check("hi_t17_y", ypos_hi, 24);
        18: begin check("hi_clamp_y", ypos_hi, 20); check("hi_clamp_air", air_hi, 1); end
        19: check("hi_t19_y", ypos_hi, 21);
        20: check("hi_t20_y", ypos_hi, 23);
        33: check("hi_t33_y", ypos_hi, 140);
        34: check("hi_vmax1_y", ypos_hi, 155);
        35: check("hi_vmax2_y", ypos_hi, 170);
        default: ;
      endcase
    end
    check("hi_min_y", miny, 20);

    // Reset in the middle of a jump
    do_reset();
    pulse_jump();
    repeat (6) do_tick();
    check("mid_pre_air", air, 1);
    base = land_cnt;
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid_rst_y", ypos, 400);
    check("mid_rst_air", air, 0);
    check("mid_rst_land", land, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_tick();
    check("mid_after_y", ypos, 400);
    check("mid_after_air", air, 0);
    check("mid_no_land", land_cnt - base, 0);

`ifdef CHARACTER_DOUBLE_JUMP_EN
    // Double jump at tick 8, third jump ignored
    do_reset();
    pulse_jump();
    repeat (7) do_tick();
    check("dj_t7_y", ypos, 343);
    pulse_jump();
    do_tick();
    check("dj_t8_y", ypos, 343);
    check("dj_t8_air", air, 1);
    do_tick();
    check("dj_t9_y", ypos, 331);
    pulse_jump();
    do_tick();
    check("dj_t10_y", ypos, 320);
    do_tick();
    check("dj_t11_y", ypos, 310);
    base = land_cnt;
    for (int k = 0; k < 60 && air; k++) do_tick();
    check("dj_landed", air, 0);
    repeat (2) @(negedge clk);
    check("dj_land_once", land_cnt - base, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
